// File: rtl/poly_div_65by33.sv
// GF(2) polynomial divider: 65-bit dividend by 33-bit divisor, one
// quotient bit per cycle, top-down from x^64 to x^deg(b).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             request, sampled only when busy=0
//   dividend[64:0]    a(x), bit i = coeff of x^i
//   divisor[32:0]     b(x)
//   busy              high while iterating
//   done              one-cycle result pulse
//   div_by_zero       set with done when b(x)=0
//   quotient[64:0]    q(x), held until next accepted start
//   remainder[31:0]   r(x), held until next accepted start
module poly_div_65by33 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [64:0] dividend,
    input  logic [32:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [64:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [64:0] r_work;
    logic [6:0]  r_k;
    logic [5:0]  r_d;
    logic [32:0] r_div;
    logic        r_busy;
    logic        r_done;
    logic        r_dbz;
    logic [64:0] r_quot;
    logic [31:0] r_rem;

    logic [5:0]  w_msb;
    logic [6:0]  w_shamt;
    logic [64:0] w_bsh;
    logic        w_hit;
    logic [64:0] w_work_nx;
    logic        w_last;
    logic        w_accept;

    // Priority encoder: highest set bit of the incoming divisor.
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < 33; i++) begin
            if (divisor[i]) w_msb = i[5:0];
        end
    end

    // k never drops below d while in DIV, so the shift is 0..64.
    assign w_shamt   = r_k - {1'b0, r_d};
    assign w_bsh     = {32'b0, r_div} << w_shamt;
    assign w_hit     = r_work[r_k];
    assign w_work_nx = w_hit ? (r_work ^ w_bsh) : r_work;
    assign w_last    = (r_k == {1'b0, r_d});
    assign w_accept  = start && (r_state != S_DIV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_k     <= '0;
            r_d     <= '0;
            r_div   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
        end else if (w_accept) begin
            r_work <= dividend;
            r_d    <= w_msb;
            r_div  <= divisor;
            r_k    <= 7'd64;
            r_quot <= '0;
            r_rem  <= '0;
            if (divisor == '0) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_dbz   <= 1'b1;
            end else begin
                r_state <= S_DIV;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_dbz   <= 1'b0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                end
                S_DIV: begin
                    r_work <= w_work_nx;
                    if (w_hit) r_quot[w_shamt] <= 1'b1;
                    if (w_last) begin
                        // All bits at and above x^d are now clear.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_rem   <= w_work_nx[31:0];
                    end else begin
                        r_k <= r_k - 7'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign quotient    = r_quot;
    assign remainder   = r_rem;

endmodule

// File: tb/tb_poly_div_65by33.sv
// Bench for poly_div_65by33: vector table, random clmul products,
// busy-start, back-to-back and mid-run reset sequences.
module tb_poly_div_65by33;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [64:0] dividend;
    logic [32:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [64:0] quotient;
    logic [31:0] remainder;

    poly_div_65by33 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    typedef struct {
        logic [64:0] a;
        logic [32:0] b;
        logic [64:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    typedef struct {
        logic [64:0] q;
        logic [31:0] r;
        logic        z;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_vec;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [64:0] act,
                       input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int deg33(input logic [32:0] b);
        int d;
        d = -1;
        for (int i = 0; i < 33; i++) if (b[i]) d = i;
        return d;
    endfunction

    function automatic logic [64:0] clmul(input logic [32:0] a,
                                          input logic [32:0] b);
        logic [64:0] p;
        p = '0;
        for (int i = 0; i < 33; i++)
            if (b[i]) p = p ^ ({32'b0, a} << i);
        return p;
    endfunction

    // Edge count (start edge = 1) at which done appears.
    function automatic int lat_of(input logic [32:0] b);
        if (b == '0) return 1;
        return 66 - deg33(b);
    endfunction

    task automatic push(input logic [64:0] q, input logic [31:0] r,
                        input logic z, input logic [32:0] b);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.z   = z;
        e.due = cyc + lat_of(b);
        sb.push_back(e);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL spurious_done: got done=1 at edge %0d required 0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", {33'b0, remainder}, {33'b0, e.r});
                chk("div_by_zero", {64'b0, div_by_zero}, {64'b0, e.z});
                chk("latency", 65'(cyc), 65'(e.due));
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 120 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got %0d pending results required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input logic [64:0] a, input logic [32:0] b,
                          input logic [64:0] q, input logic [31:0] r,
                          input logic z);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        push(q, r, z, b);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", {64'b0, busy}, {64'b0, (b != '0)});
        drain();
    endtask

    vec_t vt[6];

    initial begin
        logic [32:0] ra;
        logic [32:0] rb;
        logic [31:0] rr;
        int          d;

        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vt[0] = '{65'h7, 33'h3, 65'h2, 32'h1, 1'b0};
        vt[1] = '{65'h1_0000_0000_0000_0000, 33'h1_0000_0000,
                  65'h1_0000_0000, 32'h0, 1'b0};
        vt[2] = '{65'h1_DEAD_BEEF_CAFE_F00D, 33'h1,
                  65'h1_DEAD_BEEF_CAFE_F00D, 32'h0, 1'b0};
        vt[3] = '{65'h1_2345_6789_ABCD_EF01, 33'h0, 65'h0, 32'h0, 1'b1};
        vt[4] = '{65'h5, 33'h100, 65'h0, 32'h5, 1'b0};
        vt[5] = '{65'h5, 33'h3, 65'h3, 32'h0, 1'b0};

        #1;
        chk("reset_busy", {64'b0, busy}, 65'h0);
        chk("reset_done", {64'b0, done}, 65'h0);
        chk("reset_dbz", {64'b0, div_by_zero}, 65'h0);
        chk("reset_q", quotient, 65'h0);
        chk("reset_r", {33'b0, remainder}, 65'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].z);

        // div_by_zero held, then cleared by a valid start.
        run_op(65'h9, 33'h0, 65'h0, 32'h0, 1'b1);
        repeat (3) @(negedge clk);
        chk("dbz_held", {64'b0, div_by_zero}, 65'h1);
        @(negedge clk);
        start    = 1'b1;
        dividend = 65'h7;
        divisor  = 33'h3;
        push(65'h2, 32'h1, 1'b0, 33'h3);
        @(negedge clk);
        start = 1'b0;
        chk("dbz_cleared", {64'b0, div_by_zero}, 65'h0);
        drain();

        // Random products plus a low-degree remainder.
        for (int n = 0; n < 20; n++) begin
            ra = {1'($urandom_range(0, 1)), 32'($urandom)};
            rb = {1'($urandom_range(0, 1)), 32'($urandom)};
            rb = rb >> $urandom_range(0, 32);
            if (rb == '0) rb = 33'h1;
            d  = deg33(rb);
            rr = (d == 0) ? 32'h0 : (32'($urandom) & ((32'h1 << d) - 32'h1));
            if (n < 10) rr = '0;
            run_op(clmul(ra, rb) ^ {33'b0, rr}, rb, {32'b0, ra}, rr, 1'b0);
        end

        // start while busy is ignored; later input changes do not matter.
        @(negedge clk);
        start    = 1'b1;
        dividend = 65'h7;
        divisor  = 33'h3;
        push(65'h2, 32'h1, 1'b0, 33'h3);
        @(negedge clk);
        start    = 1'b0;
        dividend = 65'h1_FFFF_FFFF_FFFF_FFFF;
        divisor  = 33'h1;
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid_run", {64'b0, busy}, 65'h1);
        drain();

        // start held high: second op accepted in the DONE cycle.
        @(negedge clk);
        start    = 1'b1;
        dividend = 65'h1_0000_0000_0000_0000;
        divisor  = 33'h1_0000_0000;
        push(65'h1_0000_0000, 32'h0, 1'b0, 33'h1_0000_0000);
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        chk("b2b_done_seen", {64'b0, done}, 65'h1);
        dividend = 65'h7;
        divisor  = 33'h3;
        push(65'h2, 32'h1, 1'b0, 33'h3);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {64'b0, busy}, 65'h1);
        chk("b2b_q_cleared", quotient, 65'h0);
        drain();

        // Reset mid-run: immediate clear, no done pulse.
        @(negedge clk);
        start    = 1'b1;
        dividend = 65'h5;
        divisor  = 33'h3;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {64'b0, busy}, 65'h0);
        chk("rst_done", {64'b0, done}, 65'h0);
        chk("rst_q", quotient, 65'h0);
        chk("rst_r", {33'b0, remainder}, 65'h0);
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        start    = 1'b1;
        dividend = 65'h5;
        divisor  = 33'h3;
        push(65'h3, 32'h0, 1'b0, 33'h3);
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", {64'b0, busy}, 65'h1);
        drain();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
